// File: rtl/acc_pkg.sv
// Shared sizing defaults and FSM encoding for the accumulator row controller.
package acc_pkg;

  localparam int LINE_W  = 480;
  localparam int ACC_LAT = 3;
  localparam int DW      = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_tag_pipe.sv
// Tag delay line that tracks which datapath slots carry real pixels.
// It advances only on enabled cycles, so it stays aligned with a stalled datapath.
module acc_tag_pipe
  import acc_pkg::*;
#(
  parameter int DEPTH = ACC_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_tag,
  output logic o_last
);

  logic [DEPTH-1:0] r_tag;

  generate
    if (DEPTH == 1) begin : g_one
      // A single stage simply captures the tag on each enabled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag <= '0;
        end else if (i_en) begin
          r_tag <= i_tag;
        end
      end
    end else begin : g_many
      // Shift the tag one stage deeper on each enabled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag <= '0;
        end else if (i_en) begin
          r_tag <= {r_tag[DEPTH-2:0], i_tag};
        end
      end
    end
  endgenerate

  assign o_last = r_tag[DEPTH-1];

endmodule

// File: rtl/acc_row_ctrl.sv
// Row/frame sequencer for the 3-tap accumulator datapath.
// It accepts pixels through a valid/ready handshake and forwards them with a
// datapath enable. After the last pixel it flushes the pipeline with zeros.
// It also tags which datapath results belong to real pixels.
module acc_row_ctrl
  import acc_pkg::*;
#(
  parameter int LINE_W  = acc_pkg::LINE_W,
  parameter int ACC_LAT = acc_pkg::ACC_LAT,
  parameter int DW      = acc_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           cfg_rows,
  input  logic                 wt_we,
  input  logic [1:0]           wt_addr,
  input  logic signed [DW-1:0] wt_data,
  input  logic                 pix_valid,
  input  logic signed [DW-1:0] pix_data,
  output logic                 pix_ready,
  output logic                 acc_ce,
  output logic signed [DW-1:0] acc_din,
  output logic signed [DW-1:0] acc_w0,
  output logic signed [DW-1:0] acc_w1,
  output logic signed [DW-1:0] acc_w2,
  output logic                 res_valid,
  output logic [8:0]           col_idx,
  output logic [7:0]           row_idx,
  output logic                 row_done,
  output logic                 frame_done,
  output logic                 busy
);

  localparam logic [8:0] LAST_COL   = 9'(LINE_W - 1);
  localparam logic [3:0] DRAIN_LEN  = 4'(ACC_LAT);

  state_t               r_state;
  logic [8:0]           r_cnt_col;
  logic [7:0]           r_cnt_row;
  logic [7:0]           r_rows;
  logic [3:0]           r_drain;
  logic                 r_acc_ce;
  logic                 r_acc_real;
  logic signed [DW-1:0] r_acc_din;
  logic [8:0]           r_col_idx;
  logic [7:0]           r_row_idx;
  logic                 r_row_done;
  logic                 r_frame_done;
  logic signed [DW-1:0] r_stg0, r_stg1, r_stg2;
  logic signed [DW-1:0] r_w0, r_w1, r_w2;

  logic w_xfer;
  logic w_last_col;
  logic w_last_row;
  logic w_tag_last;

  assign pix_ready  = (r_state == S_RUN);
  assign w_xfer     = pix_valid & pix_ready;
  assign w_last_col = (r_cnt_col == LAST_COL);
  assign w_last_row = (r_cnt_row == (r_rows - 8'd1));

  // Staging weights take writes at any time; address 3 is a dead slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg0 <= '0;
      r_stg1 <= '0;
      r_stg2 <= '0;
    end else if (wt_we) begin
      case (wt_addr)
        2'd0:    r_stg0 <= wt_data;
        2'd1:    r_stg1 <= wt_data;
        2'd2:    r_stg2 <= wt_data;
        default: ;
      endcase
    end
  end

  // Frame FSM with registered datapath drive, indices and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt_col    <= '0;
      r_cnt_row    <= '0;
      r_rows       <= '0;
      r_drain      <= '0;
      r_acc_ce     <= 1'b0;
      r_acc_real   <= 1'b0;
      r_acc_din    <= '0;
      r_col_idx    <= '0;
      r_row_idx    <= '0;
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
      r_w0         <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
    end else begin
      r_acc_ce     <= 1'b0;
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (cfg_rows != 8'd0) begin
              r_w0      <= r_stg0;
              r_w1      <= r_stg1;
              r_w2      <= r_stg2;
              r_rows    <= cfg_rows;
              r_cnt_col <= '0;
              r_cnt_row <= '0;
              r_col_idx <= '0;
              r_row_idx <= '0;
              r_state   <= S_RUN;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_acc_ce   <= 1'b1;
            r_acc_real <= 1'b1;
            r_acc_din  <= pix_data;
            r_col_idx  <= r_cnt_col;
            r_row_idx  <= r_cnt_row;
            if (w_last_col) begin
              r_row_done <= 1'b1;
              r_cnt_col  <= '0;
              r_cnt_row  <= r_cnt_row + 8'd1;
              if (w_last_row) begin
                r_drain <= '0;
                r_state <= S_DRAIN;
              end
            end else begin
              r_cnt_col <= r_cnt_col + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == DRAIN_LEN) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_acc_ce   <= 1'b1;
            r_acc_real <= 1'b0;
            r_acc_din  <= '0;
            r_drain    <= r_drain + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  acc_tag_pipe #(
    .DEPTH (ACC_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_acc_ce),
    .i_tag  (r_acc_real),
    .o_last (w_tag_last)
  );

  assign acc_ce     = r_acc_ce;
  assign acc_din    = r_acc_din;
  assign acc_w0     = r_w0;
  assign acc_w1     = r_w1;
  assign acc_w2     = r_w2;
  assign res_valid  = r_acc_ce & w_tag_last;
  assign col_idx    = r_col_idx;
  assign row_idx    = r_row_idx;
  assign row_done   = r_row_done;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_acc_row_ctrl.sv
// Self-checking bench for acc_row_ctrl.
// A frame-level reference model predicts the ordered stream of datapath slots.
// The stream is the accepted pixels with their row/col, followed by the zero
// flush. The model also predicts which slots report a real result, and the
// pixel-ready, busy and frame-done levels.
module tb_acc_row_ctrl;

  localparam int LINE_W  = 480;
  localparam int ACC_LAT = 3;
  localparam int DW      = 8;

  typedef struct {
    logic [7:0] din;
    int         col;
    int         row;
    bit         rd;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_rows = 8'd0;
  logic          wt_we = 1'b0;
  logic [1:0]    wt_addr = 2'd0;
  logic [DW-1:0] wt_data = '0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_ready;
  logic          acc_ce;
  logic [DW-1:0] acc_din;
  logic [DW-1:0] acc_w0, acc_w1, acc_w2;
  logic          res_valid;
  logic [8:0]    col_idx;
  logic [7:0]    row_idx;
  logic          row_done, frame_done, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] stg_m [3];
  logic [7:0] act_m [3];

  acc_row_ctrl #(
    .LINE_W  (LINE_W),
    .ACC_LAT (ACC_LAT),
    .DW      (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .wt_we      (wt_we),
    .wt_addr    (wt_addr),
    .wt_data    (wt_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .acc_ce     (acc_ce),
    .acc_din    (acc_din),
    .acc_w0     (acc_w0),
    .acc_w1     (acc_w1),
    .acc_w2     (acc_w2),
    .res_valid  (res_valid),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .row_done   (row_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case a wait is never satisfied.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no summary expected one");
    $fatal(1, "[TB] watchdog");
  end

  // Write one staging weight; the model ignores address 3.
  task automatic write_wt(input logic [1:0] a, input logic [7:0] d);
    wt_we   = 1'b1;
    wt_addr = a;
    wt_data = d;
    @(negedge clk);
    wt_we = 1'b0;
    if (a != 2'd3) stg_m[int'(a)] = d;
  endtask

  // Run one frame and tally deviations from the reference model.
  // mode 0: always valid with pixels 1..LINE_W per row, 1: valid every other cycle, 2: random.
  // wr_cyc/st_cyc inject a mid-frame weight write / start pulse (-1 = none).
  task automatic run_frame(input int rows, input int mode, input int wr_cyc, input int st_cyc,
                           input bit chk_w,
                           output int n_data, output int n_drain, output int n_rv, output int n_rd,
                           output int n_fd, output int e_seq, output int e_ctl, output int e_w,
                           output bit timeout);
    int total, pushed, drain_left, ce_idx, budget, extra;
    bit in_run, prev_xfer, fd_pending, done, exp_ce, exp_fd, exp_rv, valid;
    logic [7:0] d;
    ent_t e;
    ent_t q[$];
    n_data = 0; n_drain = 0; n_rv = 0; n_rd = 0; n_fd = 0;
    e_seq = 0; e_ctl = 0; e_w = 0; timeout = 1'b1;
    total = rows * LINE_W;
    if (rows > 0) act_m = stg_m;
    pix_valid = 1'b0;
    cfg_rows  = 8'(rows);
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cfg_rows   = 8'($urandom);
    in_run     = (rows > 0);
    fd_pending = (rows == 0);
    prev_xfer  = 1'b0;
    done       = 1'b0;
    drain_left = 0;
    ce_idx     = 0;
    pushed     = 0;
    extra      = 0;
    budget     = total * 4 + ACC_LAT + 20;
    for (int cyc = 0; cyc < budget; cyc++) begin
      exp_ce = 1'b0;
      exp_fd = 1'b0;
      if (prev_xfer) begin
        exp_ce = 1'b1;
      end else if (fd_pending) begin
        exp_fd     = 1'b1;
        fd_pending = 1'b0;
      end else if (drain_left > 0) begin
        exp_ce = 1'b1;
        drain_left--;
        if (drain_left == 0) fd_pending = 1'b1;
      end
      if (acc_ce !== exp_ce) e_seq++;
      if (acc_ce === 1'b1) begin
        exp_rv = (ce_idx >= ACC_LAT) && (ce_idx < ACC_LAT + total);
        if (res_valid !== exp_rv) e_seq++;
        ce_idx++;
        if (q.size() == 0) begin
          e_seq++;
        end else begin
          e = q.pop_front();
          if (acc_din !== e.din) e_seq++;
          if (row_done !== e.rd) e_seq++;
          if (e.col >= 0) begin
            n_data++;
            if (col_idx !== 9'(e.col) || row_idx !== 8'(e.row)) e_seq++;
          end else begin
            n_drain++;
          end
        end
      end else if (res_valid !== 1'b0 || row_done !== 1'b0) begin
        e_seq++;
      end
      if (res_valid === 1'b1) n_rv++;
      if (row_done === 1'b1) n_rd++;
      if (frame_done === 1'b1) n_fd++;
      if (frame_done !== exp_fd || pix_ready !== in_run || busy !== !done) e_ctl++;
      if (chk_w && (acc_w0 !== act_m[0] || acc_w1 !== act_m[1] || acc_w2 !== act_m[2])) e_w++;
      if (exp_fd) done = 1'b1;
      if (done) begin
        extra++;
        if (extra > 3) begin
          timeout = 1'b0;
          break;
        end
      end
      if (mode == 0)      valid = 1'b1;
      else if (mode == 1) valid = ((cyc % 2) == 0);
      else                valid = ($urandom_range(0, 3) != 0);
      d = (mode == 0) ? 8'((pushed % LINE_W) + 1) : 8'($urandom);
      pix_valid = valid;
      pix_data  = d;
      wt_we = 1'b0;
      start = 1'b0;
      if (wr_cyc >= 0 && cyc == wr_cyc) begin
        wt_we = 1'b1; wt_addr = 2'd0; wt_data = 8'd7; stg_m[0] = 8'd7;
      end
      if (wr_cyc >= 0 && cyc == wr_cyc + 1) begin
        wt_we = 1'b1; wt_addr = 2'd3; wt_data = 8'($urandom);
      end
      if (st_cyc >= 0 && cyc == st_cyc) begin
        start = 1'b1; cfg_rows = 8'd9;
      end
      prev_xfer = valid && in_run;
      if (prev_xfer) begin
        e.din = d;
        e.col = pushed % LINE_W;
        e.row = pushed / LINE_W;
        e.rd  = (e.col == LINE_W - 1);
        q.push_back(e);
        pushed++;
        if (pushed == total) begin
          in_run     = 1'b0;
          drain_left = ACC_LAT;
          for (int k = 0; k < ACC_LAT; k++) begin
            e.din = 8'd0; e.col = -1; e.row = -1; e.rd = 1'b0;
            q.push_back(e);
          end
        end
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
    wt_we     = 1'b0;
    start     = 1'b0;
  endtask

  // Outputs during and just after power-on reset.
  task automatic test_reset();
    stg_m = '{8'd0, 8'd0, 8'd0};
    act_m = '{8'd0, 8'd0, 8'd0};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({acc_ce, res_valid, pix_ready, row_done, frame_done, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got %b expected 000000", {acc_ce, res_valid, pix_ready, row_done, frame_done, busy});
    end
    checks++;
    if ({acc_din, col_idx, row_idx} !== 25'd0) begin
      errors++;
      $display("[TB] FAIL reset_idx: got din=%0d col=%0d row=%0d expected all 0", acc_din, col_idx, row_idx);
    end
    checks++;
    if ({acc_w0, acc_w1, acc_w2} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL reset_wt: got %0d/%0d/%0d expected 0/0/0", acc_w0, acc_w1, acc_w2);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b ready=%b expected 0/0", busy, pix_ready);
    end
  endtask

  // Two full rows with continuous valid and pixels 1..LINE_W.
  task automatic test_full_rows();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    bit to;
    write_wt(2'd0, 8'd1);
    write_wt(2'd1, 8'd2);
    write_wt(2'd2, 8'd3);
    run_frame(2, 0, -1, -1, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL full_timeout: got no frame end expected frame end"); end
    checks++;
    if (n_data != 2 * LINE_W) begin errors++; $display("[TB] FAIL full_data_ce: got %0d expected %0d", n_data, 2 * LINE_W); end
    checks++;
    if (n_drain != ACC_LAT) begin errors++; $display("[TB] FAIL full_drain_ce: got %0d expected %0d", n_drain, ACC_LAT); end
    checks++;
    if (n_rd != 2) begin errors++; $display("[TB] FAIL full_row_done: got %0d expected 2", n_rd); end
    checks++;
    if (n_rv != 2 * LINE_W) begin errors++; $display("[TB] FAIL full_res_valid: got %0d expected %0d", n_rv, 2 * LINE_W); end
    checks++;
    if (n_fd != 1) begin errors++; $display("[TB] FAIL full_frame_done: got %0d expected 1", n_fd); end
    checks++;
    if (e_seq != 0) begin errors++; $display("[TB] FAIL full_stream: got %0d deviations expected 0", e_seq); end
    checks++;
    if (e_ctl != 0) begin errors++; $display("[TB] FAIL full_ctl: got %0d deviations expected 0", e_ctl); end
    checks++;
    if (e_w != 0) begin errors++; $display("[TB] FAIL full_weights: got %0d deviations expected 0", e_w); end
  endtask

  // Alternating valid: datapath enable must follow transfers only.
  task automatic test_toggle_valid();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    bit to;
    run_frame(2, 1, -1, -1, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL toggle_timeout: got no frame end expected frame end"); end
    checks++;
    if (n_rv != 2 * LINE_W) begin errors++; $display("[TB] FAIL toggle_res_valid: got %0d expected %0d", n_rv, 2 * LINE_W); end
    checks++;
    if (n_data != 2 * LINE_W) begin errors++; $display("[TB] FAIL toggle_data_ce: got %0d expected %0d", n_data, 2 * LINE_W); end
    checks++;
    if (e_seq != 0) begin errors++; $display("[TB] FAIL toggle_stream: got %0d deviations expected 0", e_seq); end
    checks++;
    if (e_ctl != 0) begin errors++; $display("[TB] FAIL toggle_ctl: got %0d deviations expected 0", e_ctl); end
  endtask

  // Random valid pattern and random pixel data over three rows.
  task automatic test_random_valid();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    bit to;
    run_frame(3, 2, -1, -1, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL random_timeout: got no frame end expected frame end"); end
    checks++;
    if (n_rd != 3) begin errors++; $display("[TB] FAIL random_row_done: got %0d expected 3", n_rd); end
    checks++;
    if (e_seq != 0) begin errors++; $display("[TB] FAIL random_stream: got %0d deviations expected 0", e_seq); end
    checks++;
    if (e_ctl != 0) begin errors++; $display("[TB] FAIL random_ctl: got %0d deviations expected 0", e_ctl); end
  endtask

  // Weight writes mid-frame only reach the datapath at the next start.
  task automatic test_weights();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    bit to;
    logic [7:0] a, b, c;
    a = 8'($urandom_range(8, 100));
    b = 8'($urandom);
    c = 8'($urandom);
    write_wt(2'd0, a);
    write_wt(2'd1, b);
    write_wt(2'd2, c);
    run_frame(1, 2, 100, -1, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL wt_timeout: got no frame end expected frame end"); end
    checks++;
    if (e_w != 0) begin errors++; $display("[TB] FAIL wt_held_in_run: got %0d deviations expected 0", e_w); end
    checks++;
    if (acc_w0 !== a) begin errors++; $display("[TB] FAIL wt_w0_after_frame: got %0d expected %0d", acc_w0, a); end
    write_wt(2'd3, 8'hAA);
    run_frame(1, 2, -1, -1, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (e_w != 0) begin errors++; $display("[TB] FAIL wt_new_frame: got %0d deviations expected 0", e_w); end
    checks++;
    if (acc_w0 !== 8'd7) begin errors++; $display("[TB] FAIL wt_w0_new: got %0d expected 7", acc_w0); end
    checks++;
    if (acc_w1 !== b || acc_w2 !== c) begin
      errors++;
      $display("[TB] FAIL wt_w12_new: got %0d/%0d expected %0d/%0d", acc_w1, acc_w2, b, c);
    end
  endtask

  // Zero-row frame: straight to done, never ready.
  task automatic test_zero_rows();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    bit to;
    run_frame(0, 2, -1, -1, 1'b0, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL zero_timeout: got no frame end expected frame end"); end
    checks++;
    if (n_fd != 1) begin errors++; $display("[TB] FAIL zero_frame_done: got %0d expected 1", n_fd); end
    checks++;
    if (e_ctl != 0) begin errors++; $display("[TB] FAIL zero_ctl: got %0d deviations expected 0", e_ctl); end
    checks++;
    if (n_data + n_drain != 0) begin errors++; $display("[TB] FAIL zero_ce: got %0d expected 0", n_data + n_drain); end
  endtask

  // A start pulse in the middle of a frame must not disturb it.
  task automatic test_start_ignored();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    bit to;
    run_frame(1, 2, -1, 50, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL start_ign_timeout: got no frame end expected frame end"); end
    checks++;
    if (n_data != LINE_W) begin errors++; $display("[TB] FAIL start_ign_len: got %0d expected %0d", n_data, LINE_W); end
    checks++;
    if (n_fd != 1) begin errors++; $display("[TB] FAIL start_ign_fd: got %0d expected 1", n_fd); end
    checks++;
    if (e_seq != 0 || e_ctl != 0) begin
      errors++;
      $display("[TB] FAIL start_ign_stream: got %0d/%0d deviations expected 0/0", e_seq, e_ctl);
    end
  endtask

  // Reset at row 1, col 200 abandons the frame; a restart begins at row 0, col 0.
  task automatic test_reset_mid();
    int n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w;
    int fdc, bzc;
    bit to, found;
    write_wt(2'd0, 8'd11);
    write_wt(2'd1, 8'd22);
    write_wt(2'd2, 8'd33);
    cfg_rows = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    pix_valid = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 3 * LINE_W; i++) begin
      if (acc_ce === 1'b1 && row_idx === 8'd1 && col_idx === 9'd200) begin
        found = 1'b1;
        break;
      end
      pix_data = 8'($urandom);
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL rmid_reach: got no row1/col200 expected row1/col200"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_ce, res_valid, pix_ready, row_done, frame_done, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL rmid_ctl: got %b expected 000000", {acc_ce, res_valid, pix_ready, row_done, frame_done, busy});
    end
    checks++;
    if ({acc_din, col_idx, row_idx, acc_w0, acc_w1, acc_w2} !== 49'd0) begin
      errors++;
      $display("[TB] FAIL rmid_data: got din=%0d col=%0d row=%0d w=%0d/%0d/%0d expected all 0",
               acc_din, col_idx, row_idx, acc_w0, acc_w1, acc_w2);
    end
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fdc = 0;
    bzc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fdc++;
      if (busy === 1'b1) bzc++;
    end
    checks++;
    if (fdc != 0 || bzc != 0) begin
      errors++;
      $display("[TB] FAIL rmid_abandon: got frame_done=%0d busy=%0d cycles expected 0/0", fdc, bzc);
    end
    stg_m = '{8'd0, 8'd0, 8'd0};
    run_frame(1, 2, -1, -1, 1'b1, n_data, n_drain, n_rv, n_rd, n_fd, e_seq, e_ctl, e_w, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL rmid_restart_timeout: got no frame end expected frame end"); end
    checks++;
    if (e_seq != 0) begin errors++; $display("[TB] FAIL rmid_restart_stream: got %0d deviations expected 0", e_seq); end
    checks++;
    if (e_w != 0) begin errors++; $display("[TB] FAIL rmid_restart_wt: got %0d deviations expected 0", e_w); end
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_toggle_valid();
    test_random_valid();
    test_weights();
    test_zero_rows();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_row_ctrl.md
ACC_ROW_CTRL -- requirements
Module: acc_row_ctrl

Sequences row-by-row pixel streaming and weight configuration for the 3-tap accumulator datapath (acc_multi_3).

Interface
REQ-001 SHALL have parameter LINE_W, default 480: pixels per row.
REQ-002 SHALL have parameter ACC_LAT, default 3: datapath latency in ce-enabled cycles, range 1..8.
REQ-003 SHALL have parameter DW, default 8: pixel and weight width, signed.
REQ-004 SHALL have port clk  in  1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1: one-cycle frame start request.
REQ-007 SHALL have port cfg_rows  in  8: rows per frame, sampled at start.
REQ-008 SHALL have ports wt_we  in  1, wt_addr  in  2 and wt_data  in  DW: weight write; addresses 0..2 are valid, address 3 is ignored.
REQ-009 SHALL have ports pix_valid  in  1, pix_data  in  DW and pix_ready  out  1: pixel valid/ready input.
REQ-010 SHALL have ports acc_ce  out  1 and acc_din  out  DW: datapath enable and data.
REQ-011 SHALL have ports acc_w0, acc_w1 and acc_w2  out  DW: weights to the datapath (weight_111/112/113).
REQ-012 SHALL have port res_valid  out  1: datapath dout_1..3 carry a real-pixel result this cycle.
REQ-013 SHALL have ports col_idx  out  9 and row_idx  out  8: index of the pixel currently on acc_din.
REQ-014 SHALL have ports row_done  out  1, frame_done  out  1 and busy  out  1: status pulses and level.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE: start=1 with cfg_rows>0 SHALL copy the staging weights to acc_w0..2, latch cfg_rows, clear col_idx and row_idx, and go to RUN.
REQ-017 In IDLE: start=1 with cfg_rows=0 SHALL go to DONE without entering RUN.
REQ-018 Start SHALL be ignored in every state other than IDLE.
REQ-019 Weight writes SHALL update the staging registers in any state; acc_w0..2 SHALL change only at an accepted start.
REQ-020 In RUN: pix_ready SHALL be 1 and a transfer is pix_valid&pix_ready; pix_ready SHALL be 0 in every other state.
REQ-021 On a transfer, the next cycle SHALL have acc_din=pix_data and acc_ce=1; with no transfer, acc_ce=0 and acc_din holds (datapath stalls).
REQ-022 col_idx SHALL increment per transfer and wrap LINE_W-1 -> 0, with row_done pulsing 1 cycle aligned to the acc_din of col LINE_W-1.
REQ-023 row_idx SHALL increment at each wrap.
REQ-024 The transfer of the last column of row cfg_rows-1 SHALL move the FSM to DRAIN.
REQ-025 DRAIN SHALL drive acc_ce=1 and acc_din=0 for exactly ACC_LAT cycles, then go to DONE.
REQ-026 A tag shift register of ACC_LAT bits SHALL shift on acc_ce=1 only, input 1 for real pixels and 0 for drain zeros; res_valid = acc_ce & tag[ACC_LAT-1].
REQ-027 DONE SHALL pulse frame_done for 1 cycle and go to IDLE next cycle.
REQ-028 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-029 Counters SHALL be unsigned and saturate never; LINE_W SHALL be at most 512.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE and set acc_ce, res_valid, pix_ready, row_done, frame_done and busy to 0.
REQ-031 rst_n=0 SHALL clear acc_din, col_idx, row_idx, the tags and the staging/active weights to 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done; the next start begins at row 0, col 0.

Structure
REQ-033 A shared package acc_pkg SHALL hold LINE_W, ACC_LAT, DW and the FSM state encoding.
REQ-034 The tag delay line SHALL be a sub-module acc_tag_pipe (depth ACC_LAT, shift enable).

Verification
REQ-035 Write weights 1,2,3; start with cfg_rows=2 and pix_valid=1 constantly, pixels 1..480 -> 960 acc_ce data cycles then 3 drain; row_done at cycles 480 and 960; 960 res_valid; frame_done once.
REQ-036 Toggle pix_valid 1010… -> acc_ce follows transfers only; col_idx has no gaps; res_valid count = 480*cfg_rows.
REQ-037 Write weight 7 to addr 0 during RUN -> acc_w0 unchanged until the next start, then 7; a write to addr 3 changes nothing.
REQ-038 start with cfg_rows=0 -> frame_done 1 cycle later; pix_ready never 1.
REQ-039 Assert rst_n=0 at row 1, col 200 -> all outputs 0 immediately and no frame_done; a restart yields row_idx=0, col_idx=0.
REQ-040 start pulsed during RUN -> ignored; the frame length is unchanged.
